matrix_skewer: RTL and testbench

Transmit-side counterpart of the systolic output aggregator. It accepts a complete 4x4 matrix of words in one handshake and streams it out over four lanes as seven anti-diagonal wavefronts. It sits in front of the systolic array, producing the skewed per-lane input schedule. The lane/element mapping is exactly the one the aggregator uses to rebuild a matrix: with the aggregator's count at 8+k aligned to wavefront k, the aggregator reconstructs the matrix unchanged.

---
 rtl/matrix_skewer.sv | 131 +++++++++++++
 tb/tb_matrix_skewer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_skewer.sv
// Skews a 4x4 matrix into seven anti-diagonal wavefronts over four lanes,
// producing the staggered per-lane input schedule for the systolic array.
module matrix_skewer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] m11, m12, m13, m14,
    input  logic [W-1:0] m21, m22, m23, m24,
    input  logic [W-1:0] m31, m32, m33, m34,
    input  logic [W-1:0] m41, m42, m43, m44,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         stall,
    output logic [W-1:0] d1, d2, d3, d4,
    output logic         v1, v2, v3, v4,
    output logic [2:0]   wave,
    output logic         busy,
    output logic         last
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t       state, state_n;
    logic [2:0]   wave_q, wave_n;
    logic         accept, load, emit;

    logic [W-1:0] m_in      [16];
    logic [W-1:0] mat_p0    [16];
    logic [W-1:0] src_p0    [16];
    logic [W-1:0] lane_d_p0 [4];
    logic [3:0]   lane_v_p0;
    logic [W-1:0] d_p1      [4];
    logic [3:0]   v_p1;

    assign m_in[0]  = m11;  assign m_in[1]  = m12;  assign m_in[2]  = m13;  assign m_in[3]  = m14;
    assign m_in[4]  = m21;  assign m_in[5]  = m22;  assign m_in[6]  = m23;  assign m_in[7]  = m24;
    assign m_in[8]  = m31;  assign m_in[9]  = m32;  assign m_in[10] = m33;  assign m_in[11] = m34;
    assign m_in[12] = m41;  assign m_in[13] = m42;  assign m_in[14] = m43;  assign m_in[15] = m44;

    assign busy     = (state == STREAM);
    assign last     = busy && (wave_q == 3'd6);
    assign in_ready = (state == IDLE) || (last && !stall);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_n = state;
        wave_n  = wave_q;
        load    = 1'b0;
        emit    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = STREAM;
                    wave_n  = 3'd0;
                    load    = 1'b1;
                    emit    = 1'b1;
                end
            end
            STREAM: begin
                if (!stall) begin
                    if (wave_q != 3'd6) begin
                        wave_n = wave_q + 3'd1;
                        emit   = 1'b1;
                    end else if (accept) begin
                        wave_n = 3'd0;
                        load   = 1'b1;
                        emit   = 1'b1;
                    end else begin
                        state_n = IDLE;
                        wave_n  = 3'd0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Stage p0: select the wavefront about to be presented; a fresh matrix
    // is read straight from the ports so wave 0 appears right after accept.
    always_comb begin
        int k, row, col;
        for (int i = 0; i < 16; i++)
            src_p0[4'(i)] = load ? m_in[4'(i)] : mat_p0[4'(i)];
        k = int'(wave_n);
        lane_v_p0 = 4'b0000;
        for (int j = 0; j < 4; j++) begin
            row = j + 1 + ((k > 3) ? (k - 3) : 0);
            col = k + 2 - row;
            lane_d_p0[2'(j)] = '0;
            if (row >= 1 && row <= 4 && col >= 1 && col <= 4) begin
                lane_d_p0[2'(j)] = src_p0[4'((row - 1) * 4 + col - 1)];
                lane_v_p0[2'(j)] = 1'b1;
            end
        end
    end

    // Stage p1: registered lanes; stall simply suppresses every update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wave_q <= 3'd0;
            mat_p0 <= '{default: '0};
            d_p1   <= '{default: '0};
            v_p1   <= 4'b0000;
        end else begin
            state  <= state_n;
            wave_q <= wave_n;
            if (load)
                mat_p0 <= m_in;
            if (emit) begin
                d_p1 <= lane_d_p0;
                v_p1 <= lane_v_p0;
            end else if (state_n == IDLE) begin
                d_p1 <= '{default: '0};
                v_p1 <= 4'b0000;
            end
        end
    end

    assign wave = wave_q;
    assign d1 = d_p1[0];
    assign d2 = d_p1[1];
    assign d3 = d_p1[2];
    assign d4 = d_p1[3];
    assign v1 = v_p1[0];
    assign v2 = v_p1[1];
    assign v3 = v_p1[2];
    assign v4 = v_p1[3];

endmodule

// File: tb/tb_matrix_skewer.sv
// Bench for matrix_skewer: wavefront table, directed corner sequences and a
// randomized run against an anti-diagonal reference model.
module tb_matrix_skewer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] m_drv [16];
    logic         in_valid = 1'b0;
    logic         stall = 1'b0;
    logic         in_ready;
    logic [W-1:0] d1, d2, d3, d4;
    logic         v1, v2, v3, v4;
    logic [2:0]   wave;
    logic         busy, last;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    matrix_skewer #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .m11(m_drv[0]),  .m12(m_drv[1]),  .m13(m_drv[2]),  .m14(m_drv[3]),
        .m21(m_drv[4]),  .m22(m_drv[5]),  .m23(m_drv[6]),  .m24(m_drv[7]),
        .m31(m_drv[8]),  .m32(m_drv[9]),  .m33(m_drv[10]), .m34(m_drv[11]),
        .m41(m_drv[12]), .m42(m_drv[13]), .m43(m_drv[14]), .m44(m_drv[15]),
        .in_valid(in_valid), .in_ready(in_ready), .stall(stall),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4),
        .v1(v1), .v2(v2), .v3(v3), .v4(v4),
        .wave(wave), .busy(busy), .last(last)
    );

    logic [W-1:0] dd [4];
    logic [3:0]   vv;
    assign dd[0] = d1; assign dd[1] = d2; assign dd[2] = d3; assign dd[3] = d4;
    assign vv = {v4, v3, v2, v1};

    // Reference model: holds the accepted matrix and the wavefront index.
    logic [W-1:0] mm [16];
    bit           mb;
    int           mk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mb = 0;
        mk = 0;
        for (int i = 0; i < 16; i++) mm[i] = '0;
    endtask

    // Wavefront k carries elements with r+c == k+2, lanes filled by ascending row.
    task automatic check_all(input string tag);
        logic [W-1:0] ed [4];
        logic [3:0]   ev;
        int n;
        ed = '{default: '0};
        ev = 4'b0000;
        n = 0;
        if (mb)
            for (int r = 1; r <= 4; r++)
                for (int c = 1; c <= 4; c++)
                    if (r + c == mk + 2) begin
                        ed[n] = mm[(r - 1) * 4 + c - 1];
                        ev[n] = 1'b1;
                        n++;
                    end
        chk({tag, ".busy"}, 64'(busy), 64'(mb));
        chk({tag, ".wave"}, 64'(wave), 64'(mk));
        chk({tag, ".last"}, 64'(last), 64'(mb && mk == 6));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(!mb || (mk == 6 && !stall)));
        chk({tag, ".v"}, 64'(vv), 64'(ev));
        for (int j = 0; j < 4; j++)
            chk($sformatf("%s.d%0d", tag, j + 1), 64'(dd[j]), 64'(ed[j]));
    endtask

    task automatic model_step();
        bit rdy, acc;
        rdy = !mb || (mk == 6 && !stall);
        acc = in_valid && rdy;
        if (!mb) begin
            if (acc) begin mm = m_drv; mb = 1; mk = 0; end
        end else if (!stall) begin
            if (mk < 6) mk++;
            else if (acc) begin mm = m_drv; mk = 0; end
            else begin mb = 0; mk = 0; end
        end
    endtask

    // Called at a negedge with inputs already driven.
    task automatic tick(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_mat(input logic [W-1:0] base);
        for (int r = 1; r <= 4; r++)
            for (int c = 1; c <= 4; c++)
                m_drv[(r - 1) * 4 + c - 1] = base + W'(r * 16 + c);
    endtask

    typedef struct {
        logic [W-1:0] e1, e2, e3, e4;
        logic [3:0]   ev;   // {v4,v3,v2,v1}
    } vec_t;
    vec_t tbl [7];

    initial begin
        int cnt;
        tbl[0] = '{32'h11, 32'h0,  32'h0,  32'h0,  4'b0001};
        tbl[1] = '{32'h12, 32'h21, 32'h0,  32'h0,  4'b0011};
        tbl[2] = '{32'h13, 32'h22, 32'h31, 32'h0,  4'b0111};
        tbl[3] = '{32'h14, 32'h23, 32'h32, 32'h41, 4'b1111};
        tbl[4] = '{32'h24, 32'h33, 32'h42, 32'h0,  4'b0111};
        tbl[5] = '{32'h34, 32'h43, 32'h0,  32'h0,  4'b0011};
        tbl[6] = '{32'h44, 32'h0,  32'h0,  32'h0,  4'b0001};
        set_mat('0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Single matrix against the wavefront table, inputs scrambled at wave 1.
        set_mat('0);
        in_valid = 1'b1;
        tick("acc1");
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k == 1) set_mat(32'hDEAD_0000);
            #1;
            chk($sformatf("tbl%0d.wave", k), 64'(wave), 64'(k));
            chk($sformatf("tbl%0d.d1", k), 64'(d1), 64'(tbl[k].e1));
            chk($sformatf("tbl%0d.d2", k), 64'(d2), 64'(tbl[k].e2));
            chk($sformatf("tbl%0d.d3", k), 64'(d3), 64'(tbl[k].e3));
            chk($sformatf("tbl%0d.d4", k), 64'(d4), 64'(tbl[k].e4));
            chk($sformatf("tbl%0d.v", k), 64'(vv), 64'(tbl[k].ev));
            tick("single");
        end
        #1;
        chk("single.busy_end", 64'(busy), 64'(0));

        // Back-to-back with in_valid held.
        set_mat('0);
        in_valid = 1'b1;
        tick("b2b_acc");
        set_mat(32'h100);
        cnt = 0;
        for (int cyc = 0; cyc < 18; cyc++) begin
            if (busy) cnt++;
            if (cyc == 7) begin
                chk("b2b.d1", 64'(d1), 64'h111);
                chk("b2b.wave", 64'(wave), 64'(0));
                in_valid = 1'b0;
            end
            tick("b2b");
        end
        chk("b2b.busy_cycles", 64'(cnt), 64'(14));

        // Stall for 3 cycles at wave 2.
        set_mat('0);
        in_valid = 1'b1;
        tick("st_acc");
        in_valid = 1'b0;
        tick("st");
        tick("st");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall.in_ready", 64'(in_ready), 64'(0));
            chk("stall.d1", 64'(d1), 64'h13);
            chk("stall.d3", 64'(d3), 64'h31);
            tick("stall");
        end
        stall = 1'b0;
        #1;
        chk("stall.hold4_d2", 64'(d2), 64'h22);
        chk("stall.hold4_wave", 64'(wave), 64'(2));
        tick("stall");
        chk("stall.resume_wave", 64'(wave), 64'(3));
        chk("stall.resume_d4", 64'(d4), 64'h41);
        for (int i = 0; i < 4; i++) tick("stall_tail");

        // Asynchronous reset at wave 4.
        in_valid = 1'b1;
        tick("rs_acc");
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick("rs");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst.d1", 64'(d1), 64'(0));
        chk("rst.v", 64'(vv), 64'(0));
        chk("rst.in_ready", 64'(in_ready), 64'(1));
        check_all("rst");
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        tick("rs_acc2");
        in_valid = 1'b0;
        chk("rst.restart_wave", 64'(wave), 64'(0));
        chk("rst.restart_d1", 64'(d1), 64'h11);
        for (int i = 0; i < 7; i++) tick("rs_tail");

        // Randomized run with occasional asynchronous reset.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 16; i++) m_drv[i] = $urandom;
            in_valid = ($urandom_range(0, 1) == 1);
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                check_all("rnd_rst");
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                tick("rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
